// File: rtl/lamp_fpu_sqrt_iter_pkg.sv
// Shared types and helpers for the lampFPU iterative square-root unit:
// FSM states, special-operand classification and rounding.
package lamp_fpu_sqrt_iter_pkg;

  typedef enum logic [1:0] {IDLE, SQRT, RECIP, ROUND} sqrtState_e;

  typedef enum logic [1:0] {SPC_ZERO, SPC_INF, SPC_QNAN} specKind_e;

  typedef struct packed {
    logic      special;
    logic      sign;
    specKind_e kind;
    logic      invalid;
    logic      dz;
  } sqrtSpec_t;

  // Exponent in bits [63:32], fraction in bits [31:0]; callers slice to width.
  function automatic logic [63:0] FUNC_specialExpFrac(input specKind_e   kind,
                                                      input int unsigned e_dw,
                                                      input int unsigned f_dw);
    logic [31:0] e;
    logic [31:0] f;
    e = '0;
    f = '0;
    if (kind != SPC_ZERO) e = (32'd1 << e_dw) - 32'd1;
    if (kind == SPC_QNAN) f = 32'd1 << (f_dw - 1);
    return {e, f};
  endfunction

  function automatic sqrtSpec_t FUNC_sqrtSpecial(input logic sign,
                                                 input logic isInf,
                                                 input logic isZero,
                                                 input logic isSNAN,
                                                 input logic isQNAN,
                                                 input logic inv);
    sqrtSpec_t r;
    r = '0;
    if (isSNAN) begin
      r.special = 1'b1;
      r.kind    = SPC_QNAN;
      r.invalid = 1'b1;
    end else if (isQNAN) begin
      r.special = 1'b1;
      r.kind    = SPC_QNAN;
    end else if (isZero) begin
      r.special = 1'b1;
      r.sign    = sign;
      r.kind    = inv ? SPC_INF : SPC_ZERO;
      r.dz      = inv;
    end else if (sign) begin
      r.special = 1'b1;
      r.kind    = SPC_QNAN;
      r.invalid = 1'b1;
    end else if (isInf) begin
      r.special = 1'b1;
      r.kind    = inv ? SPC_ZERO : SPC_INF;
    end
    return r;
  endfunction

  function automatic logic FUNC_rneRound(input logic lsb,
                                         input logic guard,
                                         input logic rest);
    return guard & (rest | lsb);
  endfunction

endpackage

// File: rtl/lamp_fpu_sqrt_recur.sv
// Restoring recurrence shared by square root (2 radicand bits per step)
// and reciprocal division of the root (1 quotient bit per step).
module lamp_fpu_sqrt_recur #(
  parameter int unsigned R = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_i,
  input  logic           step_i,
  input  logic           div_i,
  input  logic [2*R-1:0] rad_i,
  output logic           done_o,
  output logic [R-1:0]   root_o,
  output logic [R-1:0]   quot_o,
  output logic           remNz_o
);

  localparam int unsigned CW = $clog2(R + 1);
  localparam int unsigned TW = R + 5;
  localparam logic [R+1:0] DIV_ONE = {3'b001, {(R-1){1'b0}}};

  logic [R+1:0]   rem_q, rem_d, remIn;
  logic [2*R-1:0] rad_q, rad_d;
  logic [R-1:0]   root_q, root_d, quot_q, quot_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [TW-1:0]  sqTrial, dvTrial;
  logic           unused_bits;

  always_comb begin
    rem_d  = rem_q;
    rad_d  = rad_q;
    root_d = root_q;
    quot_d = quot_q;
    cnt_d  = cnt_q;
    // The divide starts from 1.0 on its first step, so the last sqrt step
    // and the divide initialisation never compete for the remainder.
    remIn   = (div_i && cnt_q == '0) ? DIV_ONE : rem_q;
    sqTrial = TW'({rem_q, rad_q[2*R-1 -: 2]}) - TW'({root_q, 2'b01});
    dvTrial = TW'({remIn, 1'b0}) - TW'(root_q);
    done_o  = step_i && (cnt_q == CW'(R - 1));
    if (load_i) begin
      rad_d  = rad_i;
      rem_d  = '0;
      root_d = '0;
      quot_d = '0;
      cnt_d  = '0;
    end else if (step_i) begin
      cnt_d = done_o ? '0 : cnt_q + 1'b1;
      if (div_i) begin
        quot_d = {quot_q[R-2:0], ~dvTrial[TW-1]};
        rem_d  = dvTrial[TW-1] ? {remIn[R:0], 1'b0} : dvTrial[R+1:0];
      end else begin
        rad_d  = {rad_q[2*R-3:0], 2'b00};
        root_d = {root_q[R-2:0], ~sqTrial[TW-1]};
        rem_d  = sqTrial[TW-1] ? {rem_q[R-1:0], rad_q[2*R-1 -: 2]}
                               : sqTrial[R+1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      rad_q  <= '0;
      root_q <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
    end else begin
      rem_q  <= rem_d;
      rad_q  <= rad_d;
      root_q <= root_d;
      quot_q <= quot_d;
      cnt_q  <= cnt_d;
    end
  end

  assign root_o      = root_q;
  assign quot_o      = quot_q;
  assign remNz_o     = |rem_q;
  assign unused_bits = ^{sqTrial[TW-2:R+2], dvTrial[TW-2:R+2]};

endmodule

// File: rtl/lamp_fpu_sqrt_iter.sv
// Multi-cycle sqrt / inverse-sqrt for lampFPU: FSM, exponent handling,
// special-operand preload, RNE rounding and registered result outputs.
module lamp_fpu_sqrt_iter
  import lamp_fpu_sqrt_iter_pkg::*;
#(
  parameter int unsigned E_DW = 8,
  parameter int unsigned F_DW = 7,
  parameter int unsigned G_DW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            doSqrt_i,
  input  logic            invSqrt_i,
  input  logic            signum_op_i,
  input  logic [E_DW-1:0] extExp_op_i,
  input  logic [F_DW:0]   extMant_op_i,
  input  logic            isInf_op_i,
  input  logic            isZero_op_i,
  input  logic            isSNAN_op_i,
  input  logic            isQNAN_op_i,
  output logic            ready_o,
  output logic            valid_o,
  output logic            s_res_o,
  output logic [E_DW-1:0] e_res_o,
  output logic [F_DW-1:0] f_res_o,
  output logic            invalid_o,
  output logic            dz_o,
  output logic            inexact_o
);

  localparam int unsigned R    = F_DW + 1 + G_DW;
  localparam int unsigned XRW  = 2 * R;
  localparam int unsigned XW   = E_DW + 2;
  localparam int unsigned BIAS = (1 << (E_DW - 1)) - 1;
  localparam int unsigned RSH  = 2 * (R - 1) - F_DW;
  localparam logic [R-1:0] Q_ONE = {1'b1, {(R-1){1'b0}}};

  localparam logic [63:0]     EF_INF  = FUNC_specialExpFrac(SPC_INF, E_DW, F_DW);
  localparam logic [63:0]     EF_QNAN = FUNC_specialExpFrac(SPC_QNAN, E_DW, F_DW);
  localparam logic [E_DW-1:0] E_ONES  = EF_INF[32 +: E_DW];
  localparam logic [F_DW-1:0] F_QNAN  = EF_QNAN[0 +: F_DW];

  sqrtState_e      state_q;
  logic            inv_q;
  sqrtSpec_t       spec_q, specIn;
  logic [XW-1:0]   half_q, uExp, halfIn;
  logic            uOdd;
  logic [XRW-1:0]  radIn;

  logic            valid_q, s_q, invalid_q, dz_q, inexact_q;
  logic [E_DW-1:0] e_q, specE;
  logic [F_DW-1:0] f_q, specF;

  logic            recDone, recRemNz;
  logic [R-1:0]    recRoot, recQuot;

  logic            qIsOne, sticky, rUp, inexact;
  logic [R-1:0]    mantFull;
  logic [G_DW-1:0] grBits;
  logic [F_DW+1:0] mantRnd;
  logic [XW-1:0]   expPre, expRes;
  logic            unused_bits;

  assign ready_o = (state_q == IDLE);
  assign specIn  = FUNC_sqrtSpecial(signum_op_i, isInf_op_i, isZero_op_i,
                                    isSNAN_op_i, isQNAN_op_i, invSqrt_i);

  // BIAS is odd, so the unbiased exponent is odd exactly when extExp is even;
  // an arithmetic shift of u equals (u - odd) / 2.
  assign uExp   = XW'(extExp_op_i) - XW'(BIAS);
  assign uOdd   = uExp[0];
  assign halfIn = XW'($signed(uExp) >>> 1);
  assign radIn  = XRW'(extMant_op_i) << (uOdd ? RSH + 1 : RSH);

  lamp_fpu_sqrt_recur #(
    .R (R)
  ) u_recur (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ready_o & doSqrt_i & ~specIn.special),
    .step_i  ((state_q == SQRT) || (state_q == RECIP)),
    .div_i   (state_q == RECIP),
    .rad_i   (radIn),
    .done_o  (recDone),
    .root_o  (recRoot),
    .quot_o  (recQuot),
    .remNz_o (recRemNz)
  );

  always_comb begin
    qIsOne = (recRoot == Q_ONE);
    if (inv_q) begin
      // A root of exactly 1.0 would yield 2/q = 2, so it bypasses the quotient.
      mantFull = qIsOne ? Q_ONE : recQuot;
      sticky   = recRemNz & ~qIsOne;
      expPre   = XW'(BIAS) - half_q - XW'(!qIsOne);
    end else begin
      mantFull = recRoot;
      sticky   = recRemNz;
      expPre   = XW'(BIAS) + half_q;
    end
    grBits  = mantFull[G_DW-1:0];
    rUp     = FUNC_rneRound(mantFull[G_DW], grBits[G_DW-1],
                            (|(grBits << 1)) | sticky);
    mantRnd = {1'b0, mantFull[R-1:G_DW]} + (F_DW+2)'(rUp);
    expRes  = expPre + XW'(mantRnd[F_DW+1]);
    inexact = (|grBits) | sticky;
  end

  always_comb begin
    specE = '0;
    specF = '0;
    case (spec_q.kind)
      SPC_INF:  specE = E_ONES;
      SPC_QNAN: begin
        specE = E_ONES;
        specF = F_QNAN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      inv_q     <= 1'b0;
      spec_q    <= '0;
      half_q    <= '0;
      valid_q   <= 1'b0;
      s_q       <= 1'b0;
      e_q       <= '0;
      f_q       <= '0;
      invalid_q <= 1'b0;
      dz_q      <= 1'b0;
      inexact_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: if (doSqrt_i) begin
          inv_q   <= invSqrt_i;
          spec_q  <= specIn;
          half_q  <= halfIn;
          state_q <= specIn.special ? ROUND : SQRT;
        end
        SQRT:  if (recDone) state_q <= inv_q ? RECIP : ROUND;
        RECIP: if (recDone) state_q <= ROUND;
        ROUND: begin
          valid_q <= 1'b1;
          state_q <= IDLE;
          if (spec_q.special) begin
            s_q       <= spec_q.sign;
            e_q       <= specE;
            f_q       <= specF;
            invalid_q <= spec_q.invalid;
            dz_q      <= spec_q.dz;
            inexact_q <= 1'b0;
          end else begin
            s_q       <= 1'b0;
            e_q       <= expRes[E_DW-1:0];
            f_q       <= mantRnd[F_DW-1:0];
            invalid_q <= 1'b0;
            dz_q      <= 1'b0;
            inexact_q <= inexact;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign valid_o     = valid_q;
  assign s_res_o     = s_q;
  assign e_res_o     = e_q;
  assign f_res_o     = f_q;
  assign invalid_o   = invalid_q;
  assign dz_o        = dz_q;
  assign inexact_o   = inexact_q;
  assign unused_bits = ^{expRes[XW-1:E_DW], mantRnd[F_DW]};

endmodule

// File: tb/tb_lamp_fpu_sqrt_iter.sv
// Self-checking bench for lamp_fpu_sqrt_iter: directed cases, specials,
// randomized operands against an arithmetic model, back-to-back and reset.
module tb_lamp_fpu_sqrt_iter;

  localparam int R = 10;

  typedef logic [18:0] res_t;   // {s, e[7:0], f[6:0], invalid, dz, inexact}

  logic       clk = 1'b0;
  logic       rst;
  logic       doSqrt, invSqrt, signum;
  logic [7:0] extExp, extMant;
  logic       isInf, isZero, isSNAN, isQNAN;
  logic       ready, valid, s_res, invalid, dz, inexact;
  logic [7:0] e_res;
  logic [6:0] f_res;
  res_t       obs;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lamp_fpu_sqrt_iter #(.E_DW(8), .F_DW(7), .G_DW(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .doSqrt_i     (doSqrt),
    .invSqrt_i    (invSqrt),
    .signum_op_i  (signum),
    .extExp_op_i  (extExp),
    .extMant_op_i (extMant),
    .isInf_op_i   (isInf),
    .isZero_op_i  (isZero),
    .isSNAN_op_i  (isSNAN),
    .isQNAN_op_i  (isQNAN),
    .ready_o      (ready),
    .valid_o      (valid),
    .s_res_o      (s_res),
    .e_res_o      (e_res),
    .f_res_o      (f_res),
    .invalid_o    (invalid),
    .dz_o         (dz),
    .inexact_o    (inexact)
  );

  assign obs = {s_res, e_res, f_res, invalid, dz, inexact};

  // cls = {inf, zero, snan, qnan}
  function automatic res_t model(input logic inv, input logic sgn, input logic [7:0] ex,
                                 input logic [7:0] mt, input logic [3:0] cls, output int lat);
    longint x, q, m, keep, low, num;
    int     u, half, e;
    bit     odd, sticky, up;
    lat = 1;
    if (cls[1]) return {1'b0, 8'hFF, 7'h40, 3'b100};
    if (cls[0]) return {1'b0, 8'hFF, 7'h40, 3'b000};
    if (cls[2]) return inv ? {sgn, 8'hFF, 7'h00, 3'b010} : {sgn, 8'h00, 7'h00, 3'b000};
    if (sgn)    return {1'b0, 8'hFF, 7'h40, 3'b100};
    if (cls[3]) return inv ? {1'b0, 8'h00, 7'h00, 3'b000} : {1'b0, 8'hFF, 7'h00, 3'b000};
    lat  = inv ? 2 * R + 1 : R + 1;
    u    = int'(ex) - 127;
    odd  = (u % 2) != 0;
    half = (odd ? u - 1 : u) / 2;
    x    = longint'(mt) << (odd ? 12 : 11);
    q    = longint'($floor($sqrt(real'(x))));
    while (q * q > x) q--;
    while ((q + 1) * (q + 1) <= x) q++;
    num = longint'(1) << 19;
    if (!inv) begin
      m = q; sticky = (x != q * q); e = 127 + half;
    end else if (q == 512) begin
      m = 512; sticky = 1'b0; e = 127 - half;
    end else begin
      m = num / q; sticky = (num % q) != 0; e = 127 - half - 1;
    end
    keep = m >> 2;
    low  = m & 3;
    up   = (low >= 2) && ((low & 1) != 0 || sticky || (keep & 1) != 0);
    if (up) keep++;
    if (keep == 256) begin keep = 128; e++; end
    return {1'b0, 8'(e), 7'(keep & 127), 1'b0, 1'b0, (low != 0) || sticky};
  endfunction

  task automatic drive(input logic inv, input logic sgn, input logic [7:0] ex,
                       input logic [7:0] mt, input logic [3:0] cls);
    doSqrt  = 1'b1;
    invSqrt = inv;
    signum  = sgn;
    extExp  = ex;
    extMant = mt;
    {isInf, isZero, isSNAN, isQNAN} = cls;
  endtask

  // Starts one operation and waits (bounded) for its valid_o strobe.
  task automatic run_op(input logic inv, input logic sgn, input logic [7:0] ex,
                        input logic [7:0] mt, input logic [3:0] cls,
                        output int lat, output res_t r);
    @(negedge clk);
    drive(inv, sgn, ex, mt, cls);
    @(posedge clk); #1;
    doSqrt = 1'b0;
    lat = -1;
    r = '0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (valid) begin lat = k; r = obs; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 4'b0000);
    doSqrt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid); end
    n_checks++; if (obs !== '0) begin n_fail++; $display("FAIL reset_outputs got %h want 0", obs); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sqrt_directed();
    int lat; res_t r, held;
    run_op(1'b0, 1'b0, 8'd129, 8'h80, 4'b0000, lat, r);
    n_checks++; if (lat !== 11) begin n_fail++; $display("FAIL sqrt4_latency got %0d want 11", lat); end
    n_checks++; if (r !== {1'b0, 8'd128, 7'h00, 3'b000}) begin n_fail++; $display("FAIL sqrt4_result got %h want %h", r, {1'b0, 8'd128, 7'h00, 3'b000}); end
    run_op(1'b0, 1'b0, 8'd128, 8'h80, 4'b0000, lat, r);
    n_checks++; if (lat !== 11) begin n_fail++; $display("FAIL sqrt2_latency got %0d want 11", lat); end
    n_checks++; if (r !== {1'b0, 8'd127, 7'h35, 3'b001}) begin n_fail++; $display("FAIL sqrt2_result got %h want %h", r, {1'b0, 8'd127, 7'h35, 3'b001}); end
    held = r;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL hold_valid got %b want 0", valid); end
    n_checks++; if (obs !== held) begin n_fail++; $display("FAIL hold_outputs got %h want %h", obs, held); end
  endtask

  task automatic test_inverse();
    int lat; res_t r;
    run_op(1'b1, 1'b0, 8'd129, 8'h80, 4'b0000, lat, r);
    n_checks++; if (lat !== 21) begin n_fail++; $display("FAIL inv4_latency got %0d want 21", lat); end
    n_checks++; if (r !== {1'b0, 8'd126, 7'h00, 3'b000}) begin n_fail++; $display("FAIL inv4_result got %h want %h", r, {1'b0, 8'd126, 7'h00, 3'b000}); end
    run_op(1'b1, 1'b1, 8'h00, 8'h00, 4'b0100, lat, r);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL invneg0_latency got %0d want 1", lat); end
    n_checks++; if (r !== {1'b1, 8'hFF, 7'h00, 3'b010}) begin n_fail++; $display("FAIL invneg0_result got %h want %h", r, {1'b1, 8'hFF, 7'h00, 3'b010}); end
  endtask

  task automatic test_specials();
    int lat; res_t r;
    run_op(1'b0, 1'b1, 8'd127, 8'h80, 4'b0000, lat, r);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL neg1_latency got %0d want 1", lat); end
    n_checks++; if (r !== {1'b0, 8'hFF, 7'h40, 3'b100}) begin n_fail++; $display("FAIL neg1_result got %h want %h", r, {1'b0, 8'hFF, 7'h40, 3'b100}); end
    run_op(1'b0, 1'b1, 8'hFF, 8'hA0, 4'b0010, lat, r);
    n_checks++; if (r !== {1'b0, 8'hFF, 7'h40, 3'b100}) begin n_fail++; $display("FAIL snan_result got %h want %h", r, {1'b0, 8'hFF, 7'h40, 3'b100}); end
    run_op(1'b0, 1'b1, 8'hFF, 8'hC0, 4'b0001, lat, r);
    n_checks++; if (r !== {1'b0, 8'hFF, 7'h40, 3'b000}) begin n_fail++; $display("FAIL qnan_result got %h want %h", r, {1'b0, 8'hFF, 7'h40, 3'b000}); end
    run_op(1'b0, 1'b0, 8'hFF, 8'h80, 4'b1000, lat, r);
    n_checks++; if (r !== {1'b0, 8'hFF, 7'h00, 3'b000}) begin n_fail++; $display("FAIL posinf_sqrt got %h want %h", r, {1'b0, 8'hFF, 7'h00, 3'b000}); end
    run_op(1'b1, 1'b0, 8'hFF, 8'h80, 4'b1000, lat, r);
    n_checks++; if (r !== {1'b0, 8'h00, 7'h00, 3'b000}) begin n_fail++; $display("FAIL posinf_inv got %h want %h", r, {1'b0, 8'h00, 7'h00, 3'b000}); end
    run_op(1'b0, 1'b1, 8'h00, 8'h00, 4'b0100, lat, r);
    n_checks++; if (r !== {1'b1, 8'h00, 7'h00, 3'b000}) begin n_fail++; $display("FAIL negzero_sqrt got %h want %h", r, {1'b1, 8'h00, 7'h00, 3'b000}); end
  endtask

  task automatic test_random();
    int lat, elat; res_t r, er;
    logic inv, sgn; logic [7:0] ex, mt; logic [3:0] cls; int sel;
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 9));
      inv = 1'($urandom_range(0, 1));
      sgn = 1'($urandom_range(0, 1));
      ex  = 8'($urandom_range(1, 254));
      mt  = {1'b1, 7'($urandom)};
      case (sel)
        0: cls = 4'b0100;
        1: cls = 4'b1000;
        2: cls = 4'b0010;
        3: cls = 4'b0001;
        4: begin cls = 4'b0000; sgn = 1'b1; end
        default: begin cls = 4'b0000; sgn = 1'b0; end
      endcase
      er = model(inv, sgn, ex, mt, cls, elat);
      run_op(inv, sgn, ex, mt, cls, lat, r);
      n_checks++; if (lat !== elat) begin n_fail++; $display("FAIL rand_latency op %0d got %0d want %0d", i, lat, elat); end
      n_checks++; if (r !== er) begin n_fail++; $display("FAIL rand_result op %0d inv=%b exp=%h mant=%h cls=%b got %h want %h", i, inv, ex, mt, cls, r, er); end
    end
  endtask

  task automatic test_back_to_back();
    int lat; res_t r;
    run_op(1'b0, 1'b0, 8'd129, 8'h80, 4'b0000, lat, r);
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_in_valid got %b want 1", ready); end
    drive(1'b0, 1'b0, 8'd128, 8'h80, 4'b0000);
    @(posedge clk); #1;
    doSqrt = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (valid) begin lat = k; r = obs; break; end
    end
    n_checks++; if (lat !== 11) begin n_fail++; $display("FAIL b2b_latency got %0d want 11", lat); end
    n_checks++; if (r !== {1'b0, 8'd127, 7'h35, 3'b001}) begin n_fail++; $display("FAIL b2b_result got %h want %h", r, {1'b0, 8'd127, 7'h35, 3'b001}); end
  endtask

  task automatic test_busy_ignore();
    int lat, extra; res_t r;
    @(negedge clk);
    drive(1'b0, 1'b0, 8'd129, 8'h80, 4'b0000);
    @(posedge clk); #1;
    doSqrt = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL busy_ready got %b want 0", ready); end
    @(negedge clk);
    drive(1'b1, 1'b0, 8'd128, 8'h80, 4'b0000);
    @(posedge clk); #1;
    doSqrt = 1'b0;
    lat = -1;
    r = '0;
    for (int k = 3; k <= 60; k++) begin
      @(posedge clk); #1;
      if (valid) begin lat = k; r = obs; break; end
    end
    n_checks++; if (lat !== 11) begin n_fail++; $display("FAIL busy_latency got %0d want 11", lat); end
    n_checks++; if (r !== {1'b0, 8'd128, 7'h00, 3'b000}) begin n_fail++; $display("FAIL busy_result got %h want %h", r, {1'b0, 8'd128, 7'h00, 3'b000}); end
    extra = 0;
    repeat (30) begin @(posedge clk); #1; if (valid) extra++; end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL busy_extra_valid got %0d want 0", extra); end
  endtask

  task automatic test_reset_midop();
    int lat, stray; res_t r;
    @(negedge clk);
    drive(1'b1, 1'b0, 8'd129, 8'h80, 4'b0000);
    @(posedge clk); #1;
    doSqrt = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (obs !== '0) begin n_fail++; $display("FAIL midrst_outputs got %h want 0", obs); end
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready_in_reset got %b want 1", ready); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready_after got %b want 1", ready); end
    stray = 0;
    repeat (40) begin @(posedge clk); #1; if (valid) stray++; end
    n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL midrst_stray_valid got %0d want 0", stray); end
    run_op(1'b0, 1'b0, 8'd129, 8'h80, 4'b0000, lat, r);
    n_checks++; if (lat !== 11) begin n_fail++; $display("FAIL midrst_after_latency got %0d want 11", lat); end
    n_checks++; if (r !== {1'b0, 8'd128, 7'h00, 3'b000}) begin n_fail++; $display("FAIL midrst_after_result got %h want %h", r, {1'b0, 8'd128, 7'h00, 3'b000}); end
  endtask

  initial begin
    test_reset();
    test_sqrt_directed();
    test_inverse();
    test_specials();
    test_random();
    test_back_to_back();
    test_busy_ignore();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lamp_fpu_sqrt_iter.md
# lamp_fpu_sqrt_iter

Parametrised, multi-cycle square-root / inverse-square-root unit for the lampFPU, sitting behind the operand-unpack stage alongside the other iterative units. It accepts one unpacked operand per start pulse and runs a bit-serial restoring square-root recurrence. In inverse mode it follows with a bit-serial restoring reciprocal. It then rounds round-to-nearest-even, returns a packed sign/exponent/fraction and the IEEE exception flags, and reports busy through a ready/valid pair.

## Interface
- E_DW, 8: exponent width; bias BIAS = 2^(E_DW-1)-1.
- F_DW, 7: stored fraction width.
- G_DW, 2: extra root bits (guard, round); sticky comes from the remainder. R = F_DW+1+G_DW root bits.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- doSqrt_i  in  1  start; accepted only when ready_o=1.
- invSqrt_i  in  1  mode, sampled with start: 0 = sqrt(x), 1 = 1/sqrt(x).
- signum_op_i  in  1  operand sign.
- extExp_op_i  in  E_DW  biased exponent of a normalised operand.
- extMant_op_i  in  F_DW+1  mantissa 1.f with the hidden bit at MSB.
- isInf_op_i, isZero_op_i, isSNAN_op_i, isQNAN_op_i  in  1 each  operand class; at most one is set.
- ready_o  out  1  unit idle, can accept.
- valid_o  out  1  one-cycle result strobe.
- s_res_o  out  1  result sign.
- e_res_o  out  E_DW  result exponent.
- f_res_o  out  F_DW  result fraction.
- invalid_o, dz_o, inexact_o  out  1 each  IEEE flags, qualified by valid_o.

## Operation
- FSM states: IDLE, SQRT, RECIP, ROUND.
- Accept happens when doSqrt_i & ready_o. Operand, mode and class are registered.
  - Special class: go to ROUND, with the special result preloaded.
  - Otherwise: go to SQRT.
- Exponent handling: u = extExp - BIAS.
  - u odd: radicand = 2·m, u' = u-1. Otherwise radicand = m, u' = u.
  - Root q ∈ [1,2).
  - Sqrt exponent = BIAS + u'/2 (arithmetic shift).
- SQRT state: one root bit per cycle, restoring recurrence on a (R+2)-bit partial remainder. Lasts exactly R cycles. Exit to RECIP if inverse mode, else to ROUND.
- RECIP state: restoring division 1/q, one quotient bit per cycle, exactly R cycles.
  - q == 1.0: result 1.0, exponent BIAS - u'/2.
  - q > 1.0: result is 2/q ∈ (1,2), exponent BIAS - u'/2 - 1.
- Sticky = OR of the final nonzero remainder.
- ROUND state:
  - RNE on the guard, round and sticky bits.
  - A carry out of the mantissa (round to 2.0) gives fraction 0 and exponent +1.
  - inexact_o = G|R|S.
- Special results, no inexact:
  - Any NaN input: qNaN with sign 0. invalid_o=1 only for SNAN.
  - Negative nonzero input, including -inf: qNaN, invalid_o=1.
  - ±0, sqrt mode: ±0.
  - ±0, inverse mode: ±inf, dz_o=1.
  - +inf, sqrt mode: +inf.
  - +inf, inverse mode: +0.
- qNaN encoding: exponent all ones, fraction MSB set.
- Normal inputs with sign 0 only; the result sign is always 0.
- Exponent range: no overflow or underflow is possible for normalised inputs with E_DW ≥ 3, so the unit has no overflow/underflow detection.

## Timing
- Accept edge = edge 0. valid_o is high for one cycle after:
  - sqrt mode: edge R+1;
  - inverse mode: edge 2R+1;
  - special operand: edge 1.
- Default parameters (R=10): sqrt result on edge 11, inverse result on edge 21.
- ready_o = (state==IDLE). ROUND returns to IDLE on the same edge that raises valid_o, so ready_o=1 during the valid_o cycle.
  - A start in that cycle is accepted, giving back-to-back operation with no bubble.
- doSqrt_i while ready_o=0 is ignored. There is no queueing.
- Result and flag outputs are registered and hold their value until the next valid_o.
- Reset values: ready_o=1, valid_o=0, s_res_o=0, e_res_o=0, f_res_o=0, invalid_o=0, dz_o=0, inexact_o=0; FSM in IDLE.
- Reset asserted mid-operation:
  - aborts immediately, no valid_o is produced;
  - ready_o=1 on the first edge after rst falls.

## Structure
- lampFPU_pkg gains:
  - the sqrt FSM state enum;
  - a parametrised qNaN/inf/zero exponent-fraction constant function;
  - FUNC_sqrtSpecial (class and mode to result and flags);
  - FUNC_rneRound.
- One sub-module, lamp_fpu_sqrt_recur: shared restoring step datapath, 1 bit per cycle.
  - Mode selects the sqrt step (trial = 4·rem − (4q+1)) or the divide step (trial = 2·rem − q).
  - Owns the remainder, root and quotient shift registers and an iteration counter of width clog2(R+1).
- The top level holds the FSM, exponent arithmetic, special-case preload, rounding and output registers.

## Test plan
- Sqrt 4.0 (exp 129, mant 0x80): valid at edge 11 → e=128, f=0x00, inexact=0.
- Sqrt 2.0 (exp 128, mant 0x80): valid at edge 11 → e=127, f=0x35, inexact=1.
- Inverse sqrt 4.0: valid at edge 21 → e=126, f=0x00. Inverse sqrt of -0 → s=1, e=0xFF, f=0, dz=1, valid at edge 1.
- Sqrt -1.0 → qNaN (s=0, e=0xFF, f=0x40), invalid=1. Sqrt of SNAN → qNaN, invalid=1. Sqrt of QNAN → qNaN, invalid=0.
- Back-to-back: second start during the first valid_o cycle is accepted → second valid exactly 11 cycles later. A start during busy is ignored.
- Assert rst at edge 5 of an inverse op → no valid_o ever, all outputs 0, ready_o=1 immediately after release. A subsequent sqrt 4.0 completes correctly.
